// File: rtl/signed_or_unsigned_div.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned
// per transaction, with valid/ready handshakes on both the request and result sides.
module signed_or_unsigned_div #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         sign,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] quo,
    output logic [n-1:0] rem,
    output logic         div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FIX,
        DONE
    } state_t;

    localparam int CW = $clog2(n + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [n:0]    prem_q, prem_d;
    logic [n-1:0]  dq_q, dq_d;
    logic [n-1:0]  bmag_q, bmag_d;
    logic [n-1:0]  a_raw_q, a_raw_d;
    logic          sign_q, sign_d;
    logic          a_neg_q, a_neg_d;
    logic          b_neg_q, b_neg_d;
    logic          b_zero_q, b_zero_d;
    logic [n-1:0]  quo_q, quo_d;
    logic [n-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [n+1:0]  trial;
    logic          neg_quo;
    logic          neg_rem;

    // Trial subtraction of the divisor from the shifted partial remainder;
    // the extra top bit is the borrow that decides restore versus keep.
    assign trial   = {prem_q, dq_q[n-1]} - {2'b00, bmag_q};
    assign neg_quo = sign_q & (a_neg_q ^ b_neg_q);
    assign neg_rem = sign_q & a_neg_q;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prem_d   = prem_q;
        dq_d     = dq_q;
        bmag_d   = bmag_q;
        a_raw_d  = a_raw_q;
        sign_d   = sign_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        b_zero_d = b_zero_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = sign;
                    a_neg_d  = a[n-1];
                    b_neg_d  = b[n-1];
                    dq_d     = (sign && a[n-1]) ? -a : a;
                    bmag_d   = (sign && b[n-1]) ? -b : b;
                    b_zero_d = (b == '0);
                    a_raw_d  = a;
                    prem_d   = '0;
                    cnt_d    = CW'(n);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                // Quotient bits shift into the vacated low end of the dividend.
                prem_d = trial[n+1] ? {prem_q[n-1:0], dq_q[n-1]} : trial[n:0];
                dq_d   = {dq_q[n-2:0], ~trial[n+1]};
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Most-negative / -1 needs no special branch: the magnitude
                // quotient is already the most negative bit pattern.
                if (b_zero_q) begin
                    quo_d = '1;
                    rem_d = a_raw_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = neg_quo ? -dq_q : dq_q;
                    rem_d = neg_rem ? -prem_q[n-1:0] : prem_q[n-1:0];
                    dbz_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset clears all of them, result registers included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prem_q   <= '0;
            dq_q     <= '0;
            bmag_q   <= '0;
            a_raw_q  <= '0;
            sign_q   <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prem_q   <= prem_d;
            dq_q     <= dq_d;
            bmag_q   <= bmag_d;
            a_raw_q  <= a_raw_d;
            sign_q   <= sign_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            b_zero_q <= b_zero_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quo         = quo_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Bench for signed_or_unsigned_div: a 4-bit and an 8-bit instance, each with a
// scoreboard queue filled at request time and drained at every result transfer.
module tb_signed_or_unsigned_div;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       d4_in_valid, d4_in_ready, d4_sign, d4_out_valid, d4_out_ready, d4_dbz;
    logic [3:0] d4_a, d4_b, d4_quo, d4_rem;
    logic       d8_in_valid, d8_in_ready, d8_sign, d8_out_valid, d8_out_ready, d8_dbz;
    logic [7:0] d8_a, d8_b, d8_quo, d8_rem;

    typedef struct packed {
        logic [7:0] quo;
        logic [7:0] rem;
        logic       dbz;
    } res_t;

    res_t q4[$];
    res_t q8[$];
    int   tests_run = 0;
    int   fails = 0;
    int   req4 = 0;
    int   xfer4 = 0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    signed_or_unsigned_div #(.n(4)) u_div4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .sign(d4_sign),
        .out_valid(d4_out_valid), .out_ready(d4_out_ready),
        .quo(d4_quo), .rem(d4_rem), .div_by_zero(d4_dbz)
    );

    signed_or_unsigned_div #(.n(8)) u_div8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .sign(d8_sign),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready),
        .quo(d8_quo), .rem(d8_rem), .div_by_zero(d8_dbz)
    );

    // Reference: native / and % (truncating) plus the divide-by-zero and overflow rules.
    function automatic res_t model(int w, int a, int b, bit s);
        res_t r;
        int   mask, minv, sa, sb;
        mask  = (1 << w) - 1;
        minv  = -(1 << (w - 1));
        r.dbz = 1'b0;
        if (b == 0) begin
            r.quo = 8'(mask);
            r.rem = 8'(a);
            r.dbz = 1'b1;
        end else if (s) begin
            sa = (((a >> (w - 1)) & 1) != 0) ? a - (1 << w) : a;
            sb = (((b >> (w - 1)) & 1) != 0) ? b - (1 << w) : b;
            if (sa == minv && sb == -1) begin
                r.quo = 8'(a);
                r.rem = '0;
            end else begin
                r.quo = 8'((sa / sb) & mask);
                r.rem = 8'((sa % sb) & mask);
            end
        end else begin
            r.quo = 8'(a / b);
            r.rem = 8'(a % b);
        end
        return r;
    endfunction

    // Result monitor: a transfer is sampled at the falling edge before the
    // rising edge that completes it.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (rst_n && d4_out_valid && d4_out_ready) begin
                xfer4++;
                tests_run++;
                if (q4.size() == 0) begin
                    fails++;
                    $display("FAIL d4_unexpected_result got quo=%h rem=%h required no result", d4_quo, d4_rem);
                end else begin
                    e = q4.pop_front();
                    if (d4_quo !== e.quo[3:0] || d4_rem !== e.rem[3:0] || d4_dbz !== e.dbz) begin
                        fails++;
                        $display("FAIL d4_result got quo=%h rem=%h dbz=%b required quo=%h rem=%h dbz=%b",
                                 d4_quo, d4_rem, d4_dbz, e.quo[3:0], e.rem[3:0], e.dbz);
                    end
                end
            end
            if (rst_n && d8_out_valid && d8_out_ready) begin
                tests_run++;
                if (q8.size() == 0) begin
                    fails++;
                    $display("FAIL d8_unexpected_result got quo=%0d rem=%0d required no result", d8_quo, d8_rem);
                end else begin
                    e = q8.pop_front();
                    if (d8_quo !== e.quo || d8_rem !== e.rem || d8_dbz !== e.dbz) begin
                        fails++;
                        $display("FAIL d8_result got quo=%0d rem=%0d dbz=%b required quo=%0d rem=%0d dbz=%b",
                                 d8_quo, d8_rem, d8_dbz, e.quo, e.rem, e.dbz);
                    end
                end
            end
        end
    end

    // The 4-bit consumer is always ready except while randomised back-pressure is on.
    initial begin : d4_consumer
        d4_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            d4_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic s);
        int k = 0;
        while (!d4_in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        tests_run++;
        if (!d4_in_ready) begin
            fails++;
            $display("FAIL d4_accept_timeout got in_ready=%b required 1", d4_in_ready);
        end
        d4_a = a;
        d4_b = b;
        d4_sign = s;
        d4_in_valid = 1'b1;
        q4.push_back(model(4, int'(a), int'(b), s));
        req4++;
        @(posedge clk);
        #1;
        d4_in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit push);
        int k = 0;
        while (!d8_in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        tests_run++;
        if (!d8_in_ready) begin
            fails++;
            $display("FAIL d8_accept_timeout got in_ready=%b required 1", d8_in_ready);
        end
        d8_a = a;
        d8_b = b;
        d8_sign = s;
        d8_in_valid = 1'b1;
        if (push) q8.push_back(model(8, int'(a), int'(b), s));
        @(posedge clk);
        #1;
        d8_in_valid = 1'b0;
    endtask

    task automatic drain4();
        int k = 0;
        while (q4.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        tests_run++;
        if (q4.size() != 0) begin
            fails++;
            $display("FAIL d4_drain_timeout got %0d pending results required 0", q4.size());
            q4.delete();
        end
    endtask

    task automatic drain8();
        int k = 0;
        while (q8.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        tests_run++;
        if (q8.size() != 0) begin
            fails++;
            $display("FAIL d8_drain_timeout got %0d pending results required 0", q8.size());
            q8.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({d4_in_ready, d4_out_valid, d4_quo, d4_rem, d4_dbz} !== {1'b1, 1'b0, 4'h0, 4'h0, 1'b0}) begin
            fails++;
            $display("FAIL d4_reset_state got rdy=%b vld=%b quo=%h rem=%h dbz=%b required 1 0 0 0 0",
                     d4_in_ready, d4_out_valid, d4_quo, d4_rem, d4_dbz);
        end
        tests_run++;
        if ({d8_in_ready, d8_out_valid, d8_quo, d8_rem, d8_dbz} !== {1'b1, 1'b0, 8'h0, 8'h0, 1'b0}) begin
            fails++;
            $display("FAIL d8_reset_state got rdy=%b vld=%b quo=%h rem=%h dbz=%b required 1 0 0 0 0",
                     d8_in_ready, d8_out_valid, d8_quo, d8_rem, d8_dbz);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_unsigned();
        int edges = 1;
        bit busy_ok = 1'b1;
        send4(4'd13, 4'd3, 1'b0);
        while (!d4_out_valid && edges < 40) begin
            if (d4_in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        tests_run++;
        if (edges != 6) begin
            fails++;
            $display("FAIL d4_latency got %0d edges required 6", edges);
        end
        tests_run++;
        if (!busy_ok) begin
            fails++;
            $display("FAIL d4_in_ready_while_busy got 1 required 0");
        end
        drain4();
    endtask

    task automatic test_signed();
        send4(4'b1001, 4'b0010, 1'b1);
        send4(4'b0111, 4'b1110, 1'b1);
        drain4();
    endtask

    task automatic test_special_cases();
        send4(4'd9, 4'd0, 1'b0);
        send4(4'b1000, 4'b1111, 1'b1);
        send4(4'b1011, 4'd0, 1'b1);
        drain4();
    endtask

    task automatic test_back_pressure();
        int k = 0;
        d8_out_ready = 1'b0;
        send8(8'd200, 8'd7, 1'b0, 1'b1);
        while (!d8_out_valid && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        tests_run++;
        if (!d8_out_valid) begin
            fails++;
            $display("FAIL d8_result_timeout got out_valid=0 required 1");
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({d8_out_valid, d8_in_ready, d8_quo, d8_rem} !== {1'b1, 1'b0, 8'd28, 8'd4}) begin
                fails++;
                $display("FAIL d8_held_result cycle %0d got vld=%b rdy=%b quo=%0d rem=%0d required 1 0 28 4",
                         i, d8_out_valid, d8_in_ready, d8_quo, d8_rem);
            end
            if (i == 1) begin
                d8_a = 8'd9;
                d8_b = 8'd3;
                d8_in_valid = 1'b1;
            end else begin
                d8_in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        d8_out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (d8_in_ready !== 1'b1 || d8_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL d8_after_transfer got rdy=%b vld=%b required 1 0", d8_in_ready, d8_out_valid);
        end
        send8(8'd50, 8'd5, 1'b0, 1'b1);
        tests_run++;
        if (d8_in_ready !== 1'b0) begin
            fails++;
            $display("FAIL d8_next_accept got in_ready=%b required 0", d8_in_ready);
        end
        drain8();
    endtask

    task automatic test_reset_mid_op();
        send8(8'd123, 8'd5, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({d8_out_valid, d8_in_ready, d8_quo, d8_rem, d8_dbz} !== {1'b0, 1'b1, 8'h0, 8'h0, 1'b0}) begin
            fails++;
            $display("FAIL d8_async_reset got vld=%b rdy=%b quo=%0d rem=%0d dbz=%b required 0 1 0 0 0",
                     d8_out_valid, d8_in_ready, d8_quo, d8_rem, d8_dbz);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send8(8'd100, 8'd10, 1'b0, 1'b1);
        drain8();
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic test_exhaustive();
        rand_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    send4(4'(a), 4'(b), 1'(s));
                end
            end
        end
        drain4();
        rand_ready = 1'b0;
        tests_run++;
        if (xfer4 != req4) begin
            fails++;
            $display("FAIL d4_transfer_count got %0d required %0d", xfer4, req4);
        end
    endtask

    initial begin
        d4_in_valid = 1'b0;
        d4_a = '0;
        d4_b = '0;
        d4_sign = 1'b0;
        d8_in_valid = 1'b0;
        d8_a = '0;
        d8_b = '0;
        d8_sign = 1'b0;
        d8_out_ready = 1'b1;

        test_reset();
        test_basic_unsigned();
        test_signed();
        test_special_cases();
        test_back_pressure();
        test_reset_mid_op();
        test_exhaustive();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/signed_or_unsigned_div.md
Name: signed_or_unsigned_div

Overview:
- Iterative restoring divider; the inverse of the team's signed/unsigned multiplier.
- Divides n-bit dividend a by n-bit divisor b and returns an n-bit quotient and n-bit remainder.
- A per-transaction sign bit selects two's-complement or unsigned interpretation.
- Sits behind valid/ready handshakes on both the input and output sides.
- Processes one quotient bit per clock, so it fits in arithmetic datapaths where a combinational divider is too slow.

Parameters:
- n, 8, operand, quotient and remainder width in bits (n >= 2).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  divider idle and able to accept a request.
- a  input  n  dividend.
- b  input  n  divisor.
- sign  input  1  1 = signed (two's complement), 0 = unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- quo  output  n  quotient.
- rem  output  n  remainder.
- div_by_zero  output  1  b was zero for this result.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- While rst_n = 0:
  - FSM is in IDLE, in_ready = 1, out_valid = 0.
  - quo, rem and div_by_zero are 0; internal counter and registers are cleared.
  - Asserting reset mid-operation discards the transaction; no result is produced.
- FSM states and transitions:
  - IDLE: in_ready = 1. On a rising edge with in_valid = 1, the request is accepted. The divider latches sign and the operand magnitudes (abs value when sign = 1, raw otherwise), records both operand signs and the zero-divisor flag, loads the counter with n, and moves to BUSY.
  - BUSY: in_ready = 0. Each edge shifts the partial remainder left, shifting in the next dividend MSB. It subtracts the divisor magnitude; if the result is non-negative, the quotient bit is 1 and the difference is kept, otherwise the quotient bit is 0 and the value is restored. The counter decrements. After n BUSY edges the FSM moves to FIX.
  - FIX: one edge. Applies sign correction and special cases, registers quo, rem and div_by_zero, sets out_valid = 1, and moves to DONE.
  - DONE: out_valid = 1, in_ready = 0. quo, rem and div_by_zero stay stable while out_ready = 0. On an edge with out_ready = 1, out_valid clears and the FSM returns to IDLE.
- Latency and throughput:
  - out_valid rises exactly n+2 edges after the accepting edge (accept edge, n BUSY edges, FIX edge).
  - Latency is the same for every operand value, including divide-by-zero.
  - A new request can be accepted no earlier than the edge after the result transfer; there is no same-cycle turnaround.
  - Peak throughput is one result per n+3 cycles.
- in_valid, a, b and sign are ignored outside IDLE. The consumer may hold out_ready high permanently.
- Arithmetic, unsigned (sign = 0): quo = floor(a/b), rem = a - quo*b.
- Arithmetic, signed (sign = 1):
  - The quotient truncates toward zero. quo is negated when sign(a) differs from sign(b).
  - rem takes the sign of a, and a = quo*b + rem holds.
- Divide by zero (b = 0, either mode): quo = all ones (unsigned max, or -1 when signed), rem = a, div_by_zero = 1.
- Signed overflow (a = most negative value, b = -1): quo = most negative value, rem = 0, div_by_zero = 0.
- Internal magnitudes are n bits wide. The partial remainder is n+1 bits so the abs of the most negative value and the subtraction borrow are both exact.
- div_by_zero is 0 for all non-zero divisors.

Test Plan:
- Basic unsigned, n=4: a=13, b=3, sign=0, out_ready=1 -> quo=4'd4, rem=4'd1, div_by_zero=0; out_valid rises exactly 6 edges after accept; in_ready=0 throughout.
- Signed truncation, n=4: a=4'b1001 (-7), b=4'b0010 (2), sign=1 -> quo=4'b1101 (-3), rem=4'b1111 (-1). Also a=7, b=-2 -> quo=-3, rem=1.
- Special cases, n=4:
  - a=9, b=0, sign=0 -> quo=4'hF, rem=4'd9, div_by_zero=1.
  - a=-8, b=-1, sign=1 -> quo=4'b1000, rem=0, div_by_zero=0.
  - a=-5, b=0, sign=1 -> quo=4'hF, rem=4'b1011, div_by_zero=1.
- Back-pressure, n=8: a=200, b=7, sign=0 with out_ready=0 for 5 cycles after out_valid -> quo=28 and rem=4 held stable; in_ready=0; a second in_valid pulse is ignored. Raise out_ready -> one transfer, in_ready=1 the next cycle, next request accepted.
- Reset mid-operation, n=8: assert rst_n=0 asynchronously 3 cycles into BUSY -> out_valid=0, quo=rem=0 and in_ready=1 immediately. After release, a fresh request 100/10 -> quo=10, rem=0 with no stale result.
- Exhaustive, n=4: all 256 operand pairs in both modes, back-to-back with random out_ready. Each result is checked against a reference model: the / and % operators for non-zero b, and the special-case rules above. The total transfer count equals the request count.
